// File: rtl/bus_if_8085_multi.sv
// Multi-cycle memory bus interface for the 8085-style controller: IDLE -> REQ -> DONE handshake.
// Optional request timeout with sticky bus_err is enabled by defining BUS_TIMEOUT_EN.
module bus_if_8085_multi #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    // state | meaning
    // IDLE  | no transaction, waiting for a strobe
    // REQ   | request on the bus, waiting for mem_ack
    // DONE  | one-cycle completion; a new strobe here chains the next transfer
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   strobe;
    logic   expire;

    assign strobe  = read | write;
    assign mem_req = (state == REQ);
    assign busy    = (state == REQ);
    assign done    = (state == DONE);

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt;

    // Fires in the TIMEOUT-th REQ cycle; an ack in that cycle still takes precedence.
    assign expire = (state == REQ) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            bus_err <= 1'b0;
        end else begin
            if (state != REQ)
                cnt <= '0;
            else if (!mem_ack)
                cnt <= cnt + 1'b1;
            if (expire)
                bus_err <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign expire         = 1'b0;
    assign bus_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (strobe) begin
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        mem_we    <= write;
                        state     <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_we)
                            rdata <= mem_rdata;
                        state <= DONE;
                    end else if (expire) begin
                        if (!mem_we)
                            rdata <= '1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_if_8085_multi.sv
// Bench for bus_if_8085_multi: directed scenarios plus random traffic, all outputs compared
// every cycle against a transaction-level model.
module tb_bus_if_8085_multi;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int TO = 15;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read = 1'b0, write = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          busy, done, mem_req, mem_we, bus_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    bus_if_8085_multi #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .read(read), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an outstanding transfer, its wait count and the last result.
    bit          m_out = 0, m_done = 0, m_we = 0, m_err = 0;
    int          m_wait = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_out = 0; m_done = 0; m_we = 0; m_err = 0; m_wait = 0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_out) begin
            if (mem_ack) begin
                m_out = 0; m_done = 1;
                if (!m_we) m_rdata = mem_rdata;
            end else if (TO_ON && (m_wait + 1 == TO)) begin
                m_out = 0; m_done = 1; m_err = 1;
                if (!m_we) m_rdata = '1;
            end else begin
                m_wait++;
            end
        end else begin
            m_done = 0;
            if (read || write) begin
                m_out = 1; m_we = write; m_addr = addr; m_wdata = wdata; m_wait = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("mem_req", mem_req, m_out);
        chk("busy", busy, m_out);
        chk("done", done, m_done);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("rdata", rdata, m_rdata);
        chk("bus_err", bus_err, m_err);
    end

    initial begin
        int ack_pct;
        repeat (2) @(negedge clk);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);
        reset = 1'b0;

        // Zero-wait read.
        @(negedge clk); read = 1'b1; addr = 8'h10;
        @(negedge clk); read = 1'b0;
        chk("rd0_req", mem_req, 1'b1);
        chk("rd0_addr", mem_addr, 8'h10);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        @(negedge clk);
        chk("rd0_done", done, 1'b1);
        chk("rd0_rdata", rdata, 16'h1234);
        chk("rd0_model", m_rdata, 16'h1234);
        chk("rd0_req_low", mem_req, 1'b0);
        mem_ack = 1'b0; mem_rdata = 16'h0;

        // Write with three wait cycles.
        @(negedge clk); write = 1'b1; addr = 8'h20; wdata = 16'hBEEF;
        @(negedge clk); write = 1'b0; addr = 8'h00; wdata = 16'h0;
        for (int i = 0; i < 4; i++) begin
            chk("wr3_req", mem_req, 1'b1);
            chk("wr3_we", mem_we, 1'b1);
            chk("wr3_addr", mem_addr, 8'h20);
            chk("wr3_wdata", mem_wdata, 16'hBEEF);
            chk("wr3_nodone", done, 1'b0);
            mem_ack = (i == 3);
            @(negedge clk);
        end
        chk("wr3_done", done, 1'b1);
        chk("wr3_rdata_kept", rdata, 16'h1234);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("wr3_done_once", done, 1'b0);

        // Simultaneous strobes, then a back-to-back read from DONE.
        read = 1'b1; write = 1'b1; addr = 8'h30; wdata = 16'h5555;
        @(negedge clk); read = 1'b0; write = 1'b0;
        chk("both_we", mem_we, 1'b1);
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        @(negedge clk);
        chk("both_done", done, 1'b1);
        chk("both_rdata_kept", rdata, 16'h1234);
        mem_ack = 1'b0; read = 1'b1; addr = 8'h40;
        @(negedge clk); read = 1'b0;
        chk("b2b_req", mem_req, 1'b1);
        chk("b2b_we", mem_we, 1'b0);
        chk("b2b_addr", mem_addr, 8'h40);
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        @(negedge clk);
        chk("b2b_rdata", rdata, 16'hA5A5);
        chk("b2b_model", m_rdata, 16'hA5A5);
        mem_ack = 1'b0;

        // Reset in the second REQ cycle; a later ack must be ignored.
        @(negedge clk); read = 1'b1; addr = 8'h50;
        @(negedge clk); read = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("rstmid_req", mem_req, 1'b0);
        chk("rstmid_rdata", rdata, 16'h0);
        chk("rstmid_done", done, 1'b0);
        chk("rstmid_addr", mem_addr, 8'h0);
        mem_ack = 1'b1; mem_rdata = 16'h9999;
        @(negedge clk);
        chk("rstmid_ack_req", mem_req, 1'b0);
        chk("rstmid_ack_done", done, 1'b0);
        chk("rstmid_ack_rdata", rdata, 16'h0);
        mem_ack = 1'b0;

`ifdef BUS_TIMEOUT_EN
        // Read that never gets an ack aborts after TO REQ cycles.
        @(negedge clk); read = 1'b1; addr = 8'h60;
        @(negedge clk); read = 1'b0;
        repeat (TO - 1) @(negedge clk);
        chk("to_req_last", mem_req, 1'b1);
        chk("to_err_pre", bus_err, 1'b0);
        @(negedge clk);
        chk("to_done", done, 1'b1);
        chk("to_rdata", rdata, 16'hFFFF);
        chk("to_err", bus_err, 1'b1);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", bus_err, 1'b1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("to_err_cleared", bus_err, 1'b0);
        // Ack in the limit cycle wins.
        read = 1'b1; addr = 8'h61;
        @(negedge clk); read = 1'b0;
        repeat (TO - 1) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'h4242;
        @(negedge clk); mem_ack = 1'b0;
        chk("to_ack_done", done, 1'b1);
        chk("to_ack_rdata", rdata, 16'h4242);
        chk("to_ack_err", bus_err, 1'b0);
`else
        // Without the timeout, a long wait simply stalls with no error.
        @(negedge clk); read = 1'b1; addr = 8'h60;
        @(negedge clk); read = 1'b0;
        repeat (TO + 5) @(negedge clk);
        chk("nto_still_req", mem_req, 1'b1);
        chk("nto_err", bus_err, 1'b0);
        mem_ack = 1'b1; mem_rdata = 16'h4242;
        @(negedge clk); mem_ack = 1'b0;
        chk("nto_rdata", rdata, 16'h4242);
`endif

        // Random traffic; ack-rate varies so long waits also occur.
        ack_pct = 40;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 250 == 0) ack_pct = (ack_pct == 40) ? 4 : 40;
            reset     = ($urandom_range(0, 99) < 2);
            read      = ($urandom_range(0, 2) == 0);
            write     = ($urandom_range(0, 2) == 0);
            addr      = AW'($urandom);
            wdata     = DW'($urandom);
            mem_ack   = ($urandom_range(0, 99) < ack_pct);
            mem_rdata = DW'($urandom);
        end
        @(negedge clk);
        reset = 1'b0; read = 1'b0; write = 1'b0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
